// File: rtl/led_pattern_gen_if.sv
// LED pattern generator control/status bundle: run controls in, LED bus and progress pulses out.
interface led_pattern_gen_if #(
    parameter int NB_LEDS = 4,
    parameter int NB_DIV  = 8
);
    logic               i_enable;
    logic [1:0]         i_mode;
    logic [NB_DIV-1:0]  i_div;
    logic [NB_LEDS-1:0] o_flash;
    logic               o_step;
    logic               o_wrap;

    modport master (
        output i_enable, i_mode, i_div,
        input  o_flash, o_step, o_wrap
    );

    modport slave (
        input  i_enable, i_mode, i_div,
        output o_flash, o_step, o_wrap
    );
endinterface

// File: rtl/led_pattern_gen.sv
// LED pattern generator: four patterns (rotate L/R, ping-pong, flash) stepped by a
// prescaler that fires every i_div+1 enabled clocks; all outputs registered.
module led_pattern_gen #(
    parameter int NB_LEDS = 4,
    parameter int NB_DIV  = 8
) (
    input  logic              clock,
    input  logic              i_reset,
    led_pattern_gen_if.slave  bus
);

    typedef enum logic [1:0] {
        MODE_ROT_L = 2'b00,
        MODE_ROT_R = 2'b01,
        MODE_PING  = 2'b10,
        MODE_FLASH = 2'b11
    } mode_e;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_e;

    logic [NB_LEDS-1:0] flash_q, flash_d, advance;
    logic [NB_DIV-1:0]  cnt_q, cnt_d;
    mode_e              mode_q, mode_d, mode_in;
    dir_e               dir_q, dir_d, dir_adv;
    logic               step_q, step_d, wrap_q, wrap_d;

    function automatic logic [NB_LEDS-1:0] start_of(mode_e m);
        logic [NB_LEDS-1:0] s;
        s = '0;
        case (m)
            MODE_ROT_R: s[NB_LEDS-1] = 1'b1;
            MODE_FLASH: s = '0;
            default:    s[0] = 1'b1;
        endcase
        return s;
    endfunction

    assign mode_in = mode_e'(bus.i_mode);

    // Next pattern and ping-pong direction if a step were taken this clock.
    always_comb begin
        advance = flash_q;
        dir_adv = dir_q;
        case (mode_q)
            MODE_ROT_L: advance = {flash_q[NB_LEDS-2:0], flash_q[NB_LEDS-1]};
            MODE_ROT_R: advance = {flash_q[0], flash_q[NB_LEDS-1:1]};
            MODE_PING: begin
                if (dir_q == DIR_LEFT) begin
                    advance = flash_q << 1;
                    if (advance[NB_LEDS-1]) dir_adv = DIR_RIGHT;
                end else begin
                    advance = flash_q >> 1;
                    if (advance[0]) dir_adv = DIR_LEFT;
                end
            end
            default:    advance = ~flash_q;
        endcase
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        flash_d = flash_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        dir_d   = dir_q;
        step_d  = 1'b0;
        wrap_d  = 1'b0;
        if (mode_in != mode_q) begin
            mode_d  = mode_in;
            flash_d = start_of(mode_in);
            cnt_d   = '0;
            dir_d   = DIR_LEFT;
        end else if (bus.i_enable) begin
            // >= rather than == so shrinking i_div below cnt forces an immediate step.
            if (cnt_q >= bus.i_div) begin
                cnt_d   = '0;
                flash_d = advance;
                dir_d   = dir_adv;
                step_d  = 1'b1;
                wrap_d  = (advance == start_of(mode_q));
            end else begin
                cnt_d = cnt_q + NB_DIV'(1);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            flash_q <= NB_LEDS'(1);
            cnt_q   <= '0;
            mode_q  <= MODE_ROT_L;
            dir_q   <= DIR_LEFT;
            step_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            flash_q <= flash_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            dir_q   <= dir_d;
            step_q  <= step_d;
            wrap_q  <= wrap_d;
        end
    end

    assign bus.o_flash = flash_q;
    assign bus.o_step  = step_q;
    assign bus.o_wrap  = wrap_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Bench for led_pattern_gen: directed scenarios plus random traffic, checked against a
// phase-index model (pattern computed from mode and step number within the period).
module tb_led_pattern_gen;

    localparam int N = 4;
    localparam int D = 8;

    logic clock;
    logic i_reset;
    int   total = 0;
    int   bad   = 0;

    int   m_mode, m_k, m_cnt;
    bit   m_step, m_wrap;

    led_pattern_gen_if #(.NB_LEDS(N), .NB_DIV(D)) bus ();

    led_pattern_gen #(.NB_LEDS(N), .NB_DIV(D)) dut (
        .clock   (clock),
        .i_reset (i_reset),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic int period_of(int m);
        case (m)
            0, 1:    return N;
            2:       return 2 * (N - 1);
            default: return 2;
        endcase
    endfunction

    function automatic logic [N-1:0] pattern_of(int m, int k);
        logic [N-1:0] one;
        int idx;
        one = 1;
        case (m)
            0: return one << k;
            1: return one << (N - 1 - k);
            2: begin
                idx = (k < N) ? k : 2 * (N - 1) - k;
                return one << idx;
            end
            default: return (k == 1) ? {N{1'b1}} : {N{1'b0}};
        endcase
    endfunction

    task automatic model_reset();
        m_mode = 0; m_k = 0; m_cnt = 0; m_step = 0; m_wrap = 0;
    endtask

    task automatic model_edge();
        m_step = 0;
        m_wrap = 0;
        if (int'(bus.i_mode) != m_mode) begin
            m_mode = int'(bus.i_mode);
            m_k    = 0;
            m_cnt  = 0;
        end else if (bus.i_enable) begin
            if (m_cnt >= int'(bus.i_div)) begin
                m_cnt  = 0;
                m_k    = (m_k + 1) % period_of(m_mode);
                m_step = 1;
                m_wrap = (m_k == 0);
            end else begin
                m_cnt++;
            end
        end
    endtask

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic check_model(string tag);
        check({tag, "_flash"}, 32'(bus.o_flash), 32'(pattern_of(m_mode, m_k)));
        check({tag, "_step"},  32'(bus.o_step),  32'(m_step));
        check({tag, "_wrap"},  32'(bus.o_wrap),  32'(m_wrap));
    endtask

    task automatic tick(string tag);
        @(posedge clock);
        if (i_reset) model_edge();
        #1;
        check_model(tag);
    endtask

    initial begin
        logic [N-1:0] exp_seq[6];
        logic [N-1:0] held;
        int guard;

        // Reset: 100 ns low, then rotate-left every clock.
        i_reset = 1'b0;
        bus.i_mode = 2'b00; bus.i_div = '0; bus.i_enable = 1'b1;
        model_reset();
        #50;
        check_model("reset");
        check("reset_const", 32'(bus.o_flash), 32'h1);
        #50;
        i_reset = 1'b1;
        exp_seq[0] = 4'b0010; exp_seq[1] = 4'b0100;
        exp_seq[2] = 4'b1000; exp_seq[3] = 4'b0001;
        for (int i = 0; i < 4; i++) begin
            tick("rotl");
            check("rotl_seq", 32'(bus.o_flash), 32'(exp_seq[i]));
            check("rotl_wrap", 32'(bus.o_wrap), (i == 3) ? 32'd1 : 32'd0);
        end

        // Flash at divide-by-8.
        bus.i_mode = 2'b11; bus.i_div = 8'd7;
        tick("flash_reload");
        check("flash_start", 32'(bus.o_flash), 32'h0);
        for (int i = 0; i < 32; i++) tick("flash");

        // Ping-pong at full rate.
        bus.i_mode = 2'b10; bus.i_div = '0;
        tick("ping_reload");
        exp_seq[0] = 4'b0010; exp_seq[1] = 4'b0100; exp_seq[2] = 4'b1000;
        exp_seq[3] = 4'b0100; exp_seq[4] = 4'b0010; exp_seq[5] = 4'b0001;
        for (int i = 0; i < 6; i++) begin
            tick("ping");
            check("ping_seq", 32'(bus.o_flash), 32'(exp_seq[i]));
            check("ping_wrap", 32'(bus.o_wrap), (i == 5) ? 32'd1 : 32'd0);
        end

        // Mode change mid-run: rotate left until 0100, then switch to rotate right.
        bus.i_mode = 2'b00; bus.i_div = 8'd3;
        tick("mc_reload");
        guard = 0;
        while (!(m_k == 2 && m_step) && guard < 40) begin tick("mc_run"); guard++; end
        check("mc_bound", 32'(guard < 40), 32'd1);
        bus.i_mode = 2'b01;
        tick("mc_switch");
        check("mc_switch_flash", 32'(bus.o_flash), 32'b1000);
        check("mc_switch_step", 32'(bus.o_step), 32'd0);
        for (int i = 0; i < 3; i++) tick("mc_wait");
        tick("mc_first");
        check("mc_first_step", 32'(bus.o_step), 32'd1);
        check("mc_first_flash", 32'(bus.o_flash), 32'b0100);

        // Enable gating with i_div=7, frozen at cnt=5.
        bus.i_div = 8'd7;
        guard = 0;
        while (m_cnt != 5 && guard < 40) begin tick("gate_run"); guard++; end
        check("gate_bound", 32'(guard < 40), 32'd1);
        held = bus.o_flash;
        bus.i_enable = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick("gate_off");
            check("gate_hold", 32'(bus.o_flash), 32'(held));
        end
        bus.i_enable = 1'b1;
        tick("gate_on1"); check("gate_on1_step", 32'(bus.o_step), 32'd0);
        tick("gate_on2"); check("gate_on2_step", 32'(bus.o_step), 32'd0);
        tick("gate_on3"); check("gate_on3_step", 32'(bus.o_step), 32'd1);
        guard = 0;
        while (m_cnt != 6 && guard < 40) begin tick("div_run"); guard++; end
        check("div_bound", 32'(guard < 40), 32'd1);
        bus.i_div = 8'd2;
        tick("div_shrink");
        check("div_shrink_step", 32'(bus.o_step), 32'd1);

        // Async reset while flash mode shows 1111.
        bus.i_mode = 2'b11; bus.i_div = 8'd1;
        tick("ar_reload");
        guard = 0;
        while (m_k != 1 && guard < 20) begin tick("ar_run"); guard++; end
        check("ar_bound", 32'(guard < 20), 32'd1);
        check("ar_pre", 32'(bus.o_flash), 32'hF);
        @(negedge clock);
        i_reset = 1'b0;
        model_reset();
        #1;
        check("ar_flash", 32'(bus.o_flash), 32'h1);
        check("ar_step", 32'(bus.o_step), 32'd0);
        check("ar_wrap", 32'(bus.o_wrap), 32'd0);
        tick("ar_held");
        @(negedge clock);
        i_reset = 1'b1;
        tick("ar_release");
        check("ar_release_flash", 32'(bus.o_flash), 32'h0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 15) == 0) bus.i_mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0)  bus.i_div = 8'($urandom_range(0, 4));
            bus.i_enable = ($urandom_range(0, 7) != 0);
            tick("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
